// File: rtl/snake_body_tracker.sv
// snake_body_tracker: advances the snake head on each game tick, keeps the body in a circular
// buffer, retires or keeps the tail (growth), and detects wall and self collision.
// Ports: clk, rst_n (async, active low), clk_divided (game tick, rising edge detected in clk domain),
//   dir (snake_pkg::direction), grow (food pulse), restart (leave DEAD);
//   head_x/head_y + head_new pulse, tail_x/tail_y + tail_erase pulse, length, collision (DEAD), busy.
// Build option: define SNAKE_WRAP_EN to wrap at the grid walls instead of dying.
package snake_pkg;
   typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} direction;
endpackage

module snake_body_tracker
   import snake_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int MAX_LEN  = 64,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 16,
   parameter int START_Y  = 12,
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H),
   localparam int LW = $clog2(MAX_LEN + 1),
   localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clk_divided,
   input  logic [1:0]    dir,
   input  logic          grow,
   input  logic          restart,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic          head_new,
   output logic [XW-1:0] tail_x,
   output logic [YW-1:0] tail_y,
   output logic          tail_erase,
   output logic [LW-1:0] length,
   output logic          collision,
   output logic          busy
);
   typedef enum logic [2:0] {S_INIT, S_WAIT, S_MOVE, S_SCAN, S_DEAD} state_t;
   state_t state, state_nx;
   logic [XW-1:0] body_x [MAX_LEN];
   logic [YW-1:0] body_y [MAX_LEN];
   logic [PW-1:0] wr_ptr, rd_ptr, scan_ptr, init_cnt, wr_nx, mem_wa;
   logic [LW-1:0] scan_cnt;
   logic [1:0]    last_dir, eff_dir;
   logic [XW-1:0] nx, mem_wx;
   logic [YW-1:0] ny, mem_wy;
   logic          clk_div_prev, tick, tick_pend, grow_pend, wall_hit, hit, can_grow, mem_we;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
   endfunction

   assign tick      = clk_divided & ~clk_div_prev;
   assign collision = (state == S_DEAD);
   assign busy      = (state == S_INIT) || (state == S_MOVE) || (state == S_SCAN);
   assign wr_nx     = inc(wr_ptr);
   assign hit       = (body_x[scan_ptr] == head_x) && (body_y[scan_ptr] == head_y);
   assign can_grow  = grow_pend && (length < LW'(MAX_LEN));
   // INIT lays the body out vertically below the head, oldest (lowest) segment first
   assign mem_we    = (state == S_INIT) || ((state == S_MOVE) && !wall_hit);
   assign mem_wa    = (state == S_INIT) ? init_cnt : wr_nx;
   assign mem_wx    = (state == S_INIT) ? XW'(START_X) : nx;
   assign mem_wy    = (state == S_INIT) ? YW'(START_Y + INIT_LEN - 1) - YW'(init_cnt) : ny;

   always_comb begin
      // directions differing only in bit 0 are opposites (UP/DOWN, LEFT/RIGHT)
      eff_dir = ((dir ^ last_dir) == 2'b01) ? last_dir : dir;
      nx = (eff_dir == LEFT)  ? ((head_x == '0) ? XW'(GRID_W - 1) : head_x - 1'b1) :
           (eff_dir == RIGHT) ? ((head_x == XW'(GRID_W - 1)) ? '0 : head_x + 1'b1) : head_x;
      ny = (eff_dir == UP)    ? ((head_y == '0) ? YW'(GRID_H - 1) : head_y - 1'b1) :
           (eff_dir == DOWN)  ? ((head_y == YW'(GRID_H - 1)) ? '0 : head_y + 1'b1) : head_y;
`ifdef SNAKE_WRAP_EN
      wall_hit = 1'b0;
`else
      wall_hit = ((eff_dir == UP)    && (head_y == '0))               ||
                 ((eff_dir == DOWN)  && (head_y == YW'(GRID_H - 1)))  ||
                 ((eff_dir == LEFT)  && (head_x == '0))               ||
                 ((eff_dir == RIGHT) && (head_x == XW'(GRID_W - 1)));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_INIT:  if (init_cnt == PW'(INIT_LEN - 1)) state_nx = S_WAIT;
         S_WAIT:  if (tick || tick_pend) state_nx = S_MOVE;
         S_MOVE:  state_nx = wall_hit ? S_DEAD : S_SCAN;
         S_SCAN:  state_nx = hit ? S_DEAD : (scan_cnt == LW'(1)) ? S_WAIT : S_SCAN;
         S_DEAD:  if (restart) state_nx = S_INIT;
         default: state_nx = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         body_x[mem_wa] <= mem_wx;
         body_y[mem_wa] <= mem_wy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_div_prev <= 1'b0;
         head_x       <= XW'(START_X);
         head_y       <= YW'(START_Y);
         tail_x       <= '0;
         tail_y       <= '0;
         head_new     <= 1'b0;
         tail_erase   <= 1'b0;
         length       <= LW'(INIT_LEN);
         last_dir     <= UP;
         wr_ptr       <= PW'(INIT_LEN - 1);
         rd_ptr       <= '0;
         scan_ptr     <= '0;
         scan_cnt     <= '0;
         init_cnt     <= '0;
         grow_pend    <= 1'b0;
         tick_pend    <= 1'b0;
      end else begin
         clk_div_prev <= clk_divided;
         head_new     <= 1'b0;
         tail_erase   <= 1'b0;
         if (tick && (state != S_WAIT) && (state != S_DEAD)) tick_pend <= 1'b1;
         if (grow && (state != S_DEAD)) grow_pend <= 1'b1;
         case (state)
            S_INIT: init_cnt <= init_cnt + 1'b1;
            S_WAIT: tick_pend <= 1'b0;
            S_MOVE: begin
               last_dir  <= eff_dir;
               grow_pend <= grow;
               if (!wall_hit) begin
                  head_x   <= nx;
                  head_y   <= ny;
                  wr_ptr   <= wr_nx;
                  head_new <= 1'b1;
                  if (can_grow) begin
                     length   <= length + 1'b1;
                     scan_ptr <= rd_ptr;
                     scan_cnt <= length;
                  end else begin
                     tail_x     <= body_x[rd_ptr];
                     tail_y     <= body_y[rd_ptr];
                     tail_erase <= 1'b1;
                     rd_ptr     <= inc(rd_ptr);
                     scan_ptr   <= inc(rd_ptr);
                     scan_cnt   <= length - 1'b1;
                  end
               end
            end
            S_SCAN: begin
               scan_ptr <= inc(scan_ptr);
               scan_cnt <= scan_cnt - 1'b1;
            end
            S_DEAD: begin
               if (restart) begin
                  head_x    <= XW'(START_X);
                  head_y    <= YW'(START_Y);
                  length    <= LW'(INIT_LEN);
                  last_dir  <= UP;
                  wr_ptr    <= PW'(INIT_LEN - 1);
                  rd_ptr    <= '0;
                  init_cnt  <= '0;
                  grow_pend <= 1'b0;
                  tick_pend <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_body_tracker.sv
// tb_snake_body_tracker: directed tests of snake_body_tracker (MAX_LEN reduced to 6 so the
// length limit and non-power-of-two pointer wrap are reachable quickly).
module tb_snake_body_tracker;
   localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
   logic       clk = 1'b0, rst_n = 1'b0, clk_divided = 1'b0, grow = 1'b0, restart = 1'b0;
   logic [1:0] dir = UP;
   logic [4:0] head_x, head_y, tail_x, tail_y;
   logic [2:0] length;
   logic       head_new, tail_erase, collision, busy;
   int         total = 0, bad = 0;
   int         busy_cyc;
   logic       saw_hn, saw_te, saw_both;

   snake_body_tracker #(.MAX_LEN(6)) dut (
      .clk(clk), .rst_n(rst_n), .clk_divided(clk_divided), .dir(dir), .grow(grow),
      .restart(restart), .head_x(head_x), .head_y(head_y), .head_new(head_new),
      .tail_x(tail_x), .tail_y(tail_y), .tail_erase(tail_erase), .length(length),
      .collision(collision), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; clk_divided = 1'b0; grow = 1'b0; restart = 1'b0; dir = UP;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_grow();
      @(negedge clk) grow = 1'b1;
      @(negedge clk) grow = 1'b0;
   endtask

   // one tick edge, then follow the DUT until it is idle again, recording the pulses seen
   task automatic do_tick(input logic [1:0] d);
      int n;
      dir = d; saw_hn = 0; saw_te = 0; saw_both = 0; busy_cyc = 0; n = 0;
      @(negedge clk) clk_divided = 1'b1;
      @(negedge clk) clk_divided = 1'b0;
      while (busy && n < 50) begin
         busy_cyc++;
         @(negedge clk);
         n++;
         if (head_new) saw_hn = 1;
         if (tail_erase) saw_te = 1;
         if (head_new && tail_erase) saw_both = 1;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL tick_timeout: busy still %0d after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %0d want 1", busy); end
      total++; if (collision !== 1'b0) begin bad++; $display("FAIL rst_collision: got %0d want 0", collision); end
      total++; if (head_new !== 1'b0 || tail_erase !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %0d/%0d want 0/0", head_new, tail_erase); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL init_busy_2: got %0d want 1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy_3: got %0d want 0", busy); end
      total++; if (head_x !== 5'd16 || head_y !== 5'd12) begin bad++; $display("FAIL init_head: got (%0d,%0d) want (16,12)", head_x, head_y); end
      total++; if (length !== 3'd3) begin bad++; $display("FAIL init_length: got %0d want 3", length); end
      total++; if (collision !== 1'b0) begin bad++; $display("FAIL init_collision: got %0d want 0", collision); end
   endtask

   task automatic test_move();
      do_reset();
      do_tick(RIGHT);
      total++; if (head_x !== 5'd17 || head_y !== 5'd12) begin bad++; $display("FAIL move_head: got (%0d,%0d) want (17,12)", head_x, head_y); end
      total++; if (saw_both !== 1'b1) begin bad++; $display("FAIL move_pulses_together: got %0d want 1", saw_both); end
      total++; if (tail_x !== 5'd16 || tail_y !== 5'd14) begin bad++; $display("FAIL move_tail: got (%0d,%0d) want (16,14)", tail_x, tail_y); end
      total++; if (length !== 3'd3) begin bad++; $display("FAIL move_length: got %0d want 3", length); end
      total++; if (busy_cyc !== 3) begin bad++; $display("FAIL move_busy_cycles: got %0d want 3", busy_cyc); end
   endtask

   task automatic test_reversal();
      do_reset();
      do_tick(DOWN);
      total++; if (head_x !== 5'd16 || head_y !== 5'd11) begin bad++; $display("FAIL rev_head1: got (%0d,%0d) want (16,11)", head_x, head_y); end
      total++; if (tail_x !== 5'd16 || tail_y !== 5'd14) begin bad++; $display("FAIL rev_tail1: got (%0d,%0d) want (16,14)", tail_x, tail_y); end
      do_tick(DOWN);
      total++; if (head_x !== 5'd16 || head_y !== 5'd10) begin bad++; $display("FAIL rev_head2: got (%0d,%0d) want (16,10)", head_x, head_y); end
   endtask

   task automatic test_grow();
      do_reset();
      pulse_grow();
      do_tick(UP);
      total++; if (length !== 3'd4) begin bad++; $display("FAIL grow_length: got %0d want 4", length); end
      total++; if (saw_hn !== 1'b1 || saw_te !== 1'b0) begin bad++; $display("FAIL grow_pulses: got hn=%0d te=%0d want hn=1 te=0", saw_hn, saw_te); end
      total++; if (head_x !== 5'd16 || head_y !== 5'd11) begin bad++; $display("FAIL grow_head: got (%0d,%0d) want (16,11)", head_x, head_y); end
      pulse_grow(); do_tick(UP);
      pulse_grow(); do_tick(UP);
      total++; if (length !== 3'd6) begin bad++; $display("FAIL grow_to_max: got %0d want 6", length); end
      total++; if (busy_cyc !== 6) begin bad++; $display("FAIL grow_busy_cycles: got %0d want 6", busy_cyc); end
      pulse_grow(); do_tick(UP);
      total++; if (length !== 3'd6) begin bad++; $display("FAIL max_length: got %0d want 6", length); end
      total++; if (saw_te !== 1'b1) begin bad++; $display("FAIL max_tail_erase: got %0d want 1", saw_te); end
      total++; if (tail_x !== 5'd16 || tail_y !== 5'd14) begin bad++; $display("FAIL max_tail: got (%0d,%0d) want (16,14)", tail_x, tail_y); end
      total++; if (head_x !== 5'd16 || head_y !== 5'd8) begin bad++; $display("FAIL max_head: got (%0d,%0d) want (16,8)", head_x, head_y); end
      do_tick(UP);
      total++; if (length !== 3'd6 || saw_te !== 1'b1) begin bad++; $display("FAIL lost_grow: got len=%0d te=%0d want len=6 te=1", length, saw_te); end
      total++; if (tail_x !== 5'd16 || tail_y !== 5'd13) begin bad++; $display("FAIL wrap_ptr_tail: got (%0d,%0d) want (16,13)", tail_x, tail_y); end
   endtask

   task automatic test_tick_pend();
      do_reset();
      dir = RIGHT;
      @(negedge clk) clk_divided = 1'b1;
      @(negedge clk) clk_divided = 1'b0;
      @(negedge clk) clk_divided = 1'b1;
      @(negedge clk) clk_divided = 1'b0;
      repeat (15) @(negedge clk);
      total++; if (head_x !== 5'd18 || head_y !== 5'd12) begin bad++; $display("FAIL pend_head: got (%0d,%0d) want (18,12)", head_x, head_y); end
      total++; if (tail_x !== 5'd16 || tail_y !== 5'd13) begin bad++; $display("FAIL pend_tail: got (%0d,%0d) want (16,13)", tail_x, tail_y); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL pend_idle: got %0d want 0", busy); end
   endtask

   task automatic test_abort_reset();
      do_reset();
      dir = RIGHT;
      @(negedge clk) clk_divided = 1'b1;
      @(negedge clk) clk_divided = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (head_x !== 5'd16 || head_y !== 5'd12) begin bad++; $display("FAIL abort_head: got (%0d,%0d) want (16,12)", head_x, head_y); end
      total++; if (busy !== 1'b1 || head_new !== 1'b0) begin bad++; $display("FAIL abort_state: got busy=%0d hn=%0d want busy=1 hn=0", busy, head_new); end
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_wall();
      do_reset();
      for (int i = 0; i < 7; i++) do_tick(UP);
      for (int i = 0; i < 15; i++) do_tick(RIGHT);
      total++; if (head_x !== 5'd31 || head_y !== 5'd5 || collision !== 1'b0) begin bad++; $display("FAIL wall_approach: got (%0d,%0d) c=%0d want (31,5) c=0", head_x, head_y, collision); end
      do_tick(RIGHT);
`ifdef SNAKE_WRAP_EN
      total++; if (head_x !== 5'd0 || head_y !== 5'd5) begin bad++; $display("FAIL wrap_head: got (%0d,%0d) want (0,5)", head_x, head_y); end
      total++; if (collision !== 1'b0 || saw_hn !== 1'b1) begin bad++; $display("FAIL wrap_state: got c=%0d hn=%0d want c=0 hn=1", collision, saw_hn); end
`else
      total++; if (collision !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wall_dead: got c=%0d busy=%0d want c=1 busy=0", collision, busy); end
      total++; if (head_x !== 5'd31 || head_y !== 5'd5) begin bad++; $display("FAIL wall_head: got (%0d,%0d) want (31,5)", head_x, head_y); end
      total++; if (saw_hn !== 1'b0 || saw_te !== 1'b0) begin bad++; $display("FAIL wall_pulses: got hn=%0d te=%0d want 0/0", saw_hn, saw_te); end
      do_tick(UP);
      total++; if (head_x !== 5'd31 || head_y !== 5'd5 || collision !== 1'b1) begin bad++; $display("FAIL dead_frozen: got (%0d,%0d) c=%0d want (31,5) c=1", head_x, head_y, collision); end
`endif
   endtask

   task automatic test_self_collision();
      do_reset();
      pulse_grow(); do_tick(UP);
      pulse_grow(); do_tick(UP);
      total++; if (length !== 3'd5 || head_y !== 5'd10) begin bad++; $display("FAIL self_setup: got len=%0d y=%0d want len=5 y=10", length, head_y); end
      do_tick(RIGHT);
      do_tick(DOWN);
      total++; if (collision !== 1'b0) begin bad++; $display("FAIL self_early: got %0d want 0", collision); end
      do_tick(LEFT);
      total++; if (collision !== 1'b1) begin bad++; $display("FAIL self_collision: got %0d want 1", collision); end
      total++; if (head_x !== 5'd16 || head_y !== 5'd11) begin bad++; $display("FAIL self_head: got (%0d,%0d) want (16,11)", head_x, head_y); end
      total++; if (busy_cyc !== 2) begin bad++; $display("FAIL self_latency: got %0d want 2", busy_cyc); end
      do_tick(UP);
      total++; if (head_x !== 5'd16 || head_y !== 5'd11 || length !== 3'd5) begin bad++; $display("FAIL self_frozen: got (%0d,%0d) len=%0d want (16,11) len=5", head_x, head_y, length); end
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (head_x !== 5'd16 || head_y !== 5'd12 || length !== 3'd3) begin bad++; $display("FAIL restart_state: got (%0d,%0d) len=%0d want (16,12) len=3", head_x, head_y, length); end
      total++; if (collision !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL restart_flags: got c=%0d busy=%0d want 0/0", collision, busy); end
      do_tick(UP);
      total++; if (head_y !== 5'd11 || tail_x !== 5'd16 || tail_y !== 5'd14) begin bad++; $display("FAIL restart_body: got head_y=%0d tail=(%0d,%0d) want 11 (16,14)", head_y, tail_x, tail_y); end
   endtask

   initial begin
      test_reset();
      test_move();
      test_reversal();
      test_grow();
      test_tick_pend();
      test_abort_reset();
      test_wall();
      test_self_collision();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
